// File: rtl/hpf_dc_block.sv
// One-pole DC-blocking high-pass filter, y[n] = alpha*(y[n-1] + x[n] - x[n-1]),
// with alpha applied by a serial shift-add multiplier (one alpha bit per cycle).
module hpf_dc_block #(
    parameter int          WIDTH   = 10,
    parameter int          SCALE   = 15,
    parameter int unsigned ALPHA_Q = 31785,
    parameter int          SETTLE  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] x_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] y_out,
    output logic                    settled
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] OUT  = 2'd2;

    localparam int SW = WIDTH + 2;
    localparam int AW = WIDTH + 2 + SCALE;
    localparam int KW = $clog2(SCALE + 1);
    localparam int CW = $clog2(SETTLE + 1);

    localparam logic [SCALE-1:0]      ALPHA_BITS = SCALE'(ALPHA_Q);
    localparam logic [KW-1:0]         K_LAST     = KW'(SCALE - 1);
    localparam logic [CW-1:0]         COUNT_MAX  = CW'(SETTLE);
    localparam logic signed [AW-1:0]  HALF       = {{(AW-SCALE){1'b0}}, 1'b1, {(SCALE-1){1'b0}}};
    localparam logic signed [WIDTH-1:0] Y_MAX    = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] Y_MIN    = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]              state;
    logic signed [WIDTH-1:0] x_prev;
    logic signed [WIDTH-1:0] y_prev;
    logic signed [AW-1:0]    acc;
    logic signed [AW-1:0]    mcand;
    logic [KW-1:0]           k;
    logic [CW-1:0]           count;

    logic signed [SW-1:0]    s_in;
    logic signed [AW-1:0]    acc_add;
    logic signed [AW-1:0]    acc_rnd;
    logic signed [SW-1:0]    r_val;
    logic signed [WIDTH-1:0] y_sat;

    // Handshake: a transfer happens on a rising edge where valid and ready are both
    // high; valid never depends on ready, and y_out is held stable while out_valid waits.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == OUT);
    assign settled   = (count == COUNT_MAX);

    assign s_in = {{2{y_prev[WIDTH-1]}}, y_prev}
                + {{2{x_in[WIDTH-1]}}, x_in}
                - {{2{x_prev[WIDTH-1]}}, x_prev};

    always_comb begin
        acc_add = ALPHA_BITS[k] ? (acc + mcand) : acc;
        acc_rnd = acc_add + HALF;
        r_val   = SW'(acc_rnd >>> SCALE);
        if ((&r_val[SW-1:WIDTH-1]) || !(|r_val[SW-1:WIDTH-1])) begin
            y_sat = r_val[WIDTH-1:0];
        end else begin
            y_sat = r_val[SW-1] ? Y_MIN : Y_MAX;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            x_prev <= '0;
            y_prev <= '0;
            y_out  <= '0;
            acc    <= '0;
            mcand  <= '0;
            k      <= '0;
            count  <= '0;
        end else if (clr) begin
            state  <= IDLE;
            x_prev <= '0;
            y_prev <= '0;
            y_out  <= '0;
            count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_prev <= x_in;
                        acc    <= '0;
                        mcand  <= {{(AW-SW){s_in[SW-1]}}, s_in};
                        k      <= '0;
                        state  <= MUL;
                    end
                end
                MUL: begin
                    // mcand carries s<<<k, so each cycle adds the next alpha bit's partial product
                    acc   <= acc_add;
                    mcand <= mcand << 1;
                    k     <= k + 1'b1;
                    if (k == K_LAST) begin
                        y_out  <= y_sat;
                        y_prev <= y_sat;
                        state  <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        if (count != COUNT_MAX) begin
                            count <= count + 1'b1;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hpf_dc_block.sv
// Directed bench for hpf_dc_block: reset, step, DC decay, saturation,
// backpressure and clear, checked against hand values and a small reference model.
module tb_hpf_dc_block;

    localparam int WIDTH   = 10;
    localparam int SCALE   = 15;
    localparam int ALPHA_Q = 31785;
    localparam int SETTLE  = 16;

    logic                    clk       = 1'b0;
    logic                    rst_n     = 1'b0;
    logic                    clr       = 1'b0;
    logic                    in_valid  = 1'b0;
    logic                    out_ready = 1'b1;
    logic signed [WIDTH-1:0] x_in      = '0;
    logic                    in_ready;
    logic                    out_valid;
    logic                    settled;
    logic signed [WIDTH-1:0] y_out;

    int checks = 0;
    int errors = 0;
    int xp = 0;
    int yp = 0;

    hpf_dc_block #(
        .WIDTH(WIDTH), .SCALE(SCALE), .ALPHA_Q(ALPHA_Q), .SETTLE(SETTLE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in),
        .out_valid(out_valid), .out_ready(out_ready), .y_out(y_out),
        .settled(settled)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: exact alpha product, round half up, then clip to the output range.
    function automatic int model_step(input int x);
        int s;
        int r;
        s = yp + x - xp;
        r = (s * ALPHA_Q + (1 << (SCALE - 1))) >>> SCALE;
        if (r > 511) r = 511;
        if (r < -512) r = -512;
        xp = x;
        yp = r;
        return r;
    endfunction

    // Offer x at a negedge, then measure edges from the accepting edge to out_valid.
    task automatic push(input int x, input int exp, input string tag, output int y);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_rdy"}, in_ready, 1);
        x_in     = WIDTH'(x);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_lat"}, n, SCALE);
        check({tag, "_y"}, y_out, exp);
        y = y_out;
        if (out_ready) @(negedge clk);
    endtask

    initial begin
        int y;
        int e;
        int prev;
        int hits;
        int n;
        logic seen;

        // reset values
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_y_out", y_out, 0);
        check("rst_settled", settled, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // T1: async reset in the middle of a multiply
        push(100, 97, "t1_pre", y);
        x_in     = 10'sd100;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("t1_busy", in_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        check("t1_async_y", y_out, 0);
        check("t1_async_valid", out_valid, 0);
        check("t1_async_ready", in_ready, 1);
        check("t1_async_settled", settled, 0);
        @(negedge clk);
        rst_n = 1'b1;
        xp = 0;
        yp = 0;
        @(negedge clk);
        check("t1_ready_after", in_ready, 1);

        // T2: step from cleared state, then a repeat shows x_prev was 100
        push(100, 97, "t2_step", y);
        void'(model_step(100));
        push(100, 94, "t2_second", y);
        void'(model_step(100));

        // T3: DC input decays monotonically to the +16 dead-band
        prev = 94;
        hits = 0;
        for (int i = 0; i < 200 && hits < 3; i++) begin
            e = model_step(100);
            push(100, e, "t3_dc", y);
            check("t3_mono", (y <= prev), 1);
            prev = y;
            if (y == 16) hits++;
        end
        check("t3_floor", y, 16);
        check("t3_settled", settled, 1);

        // T4: negative DC to -16, then a full-scale jump that clips
        hits = 0;
        for (int i = 0; i < 300 && hits < 1; i++) begin
            e = model_step(-512);
            push(-512, e, "t4_neg", y);
            if (y == -16) hits++;
        end
        check("t4_neg_floor", y, -16);
        push(511, 511, "t4_clip", y);
        void'(model_step(511));
        push(511, 496, "t4_after_clip", y);
        void'(model_step(511));

        // T5: backpressure holds the result; a waiting sample enters only from IDLE
        out_ready = 1'b0;
        e = model_step(7);
        push(7, e, "t5_first", y);
        x_in     = 10'sd200;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t5_hold_valid", out_valid, 1);
            check("t5_hold_y", y_out, e);
            check("t5_hold_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("t5_idle_ready", in_ready, 1);
        check("t5_released", out_valid, 0);
        @(negedge clk);
        in_valid = 1'b0;
        check("t5_accepted", in_ready, 0);
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("t5_lat", n, SCALE);
        e = model_step(200);
        check("t5_y", y_out, e);
        @(negedge clk);

        // T6: clear during a multiply discards the result and restarts settling
        check("t6_pre_settled", settled, 1);
        x_in     = 10'sd50;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("t6_clr_valid", out_valid, 0);
        check("t6_clr_ready", in_ready, 1);
        check("t6_clr_settled", settled, 0);
        check("t6_clr_y", y_out, 0);
        clr      = 1'b1;
        x_in     = 10'sd300;
        in_valid = 1'b1;
        @(negedge clk);
        clr      = 1'b0;
        in_valid = 1'b0;
        check("t6_clr_reject", in_ready, 1);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
        check("t6_no_output", seen, 0);
        xp = 0;
        yp = 0;
        push(100, 97, "t6_step", y);
        void'(model_step(100));
        for (int i = 2; i <= SETTLE; i++) begin
            e = model_step(100);
            push(100, e, "t6_run", y);
            if (i == SETTLE - 1) check("t6_not_yet", settled, 0);
        end
        check("t6_settled", settled, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
